// File: rtl/mrv1_tw_pkg.sv
// Shared types for the warp round-robin scheduler: per-warp state record,
// barrier counter type and the reset-state helper.
package mrv1_tw_pkg;

  localparam int unsigned PC_W          = 32;
  // Upper bound on WARP_SIZE_P; thread masks are held zero-extended to this width.
  localparam int unsigned TMASK_MAX_W   = 32;
  // Upper bound on TW_ID_W; barrier counts are held zero-extended to this width.
  localparam int unsigned BAR_CNT_MAX_W = 8;

  typedef struct packed {
    logic                   active;
    logic                   stalled;
    logic                   locked;
    logic [TMASK_MAX_W-1:0] tmask;
    logic [PC_W-1:0]        pc;
  } tw_state_t;

  typedef logic [BAR_CNT_MAX_W-1:0] bar_cnt_t;

  function automatic tw_state_t tw_reset_state(input logic boot, input logic [PC_W-1:0] boot_pc);
    tw_state_t s;
    s        = '0;
    s.active = boot;
    s.tmask  = {{(TMASK_MAX_W-1){1'b0}}, boot};
    s.pc     = boot ? boot_pc : {PC_W{1'b0}};
    return s;
  endfunction

endpackage

// File: rtl/mrv1_rr_arbiter.sv
// Round-robin selector: grants the first requester found scanning
// ptr+1, ptr+2, ... wrapping back to ptr itself.
module mrv1_rr_arbiter #(
  parameter  int NUM_P = 8,
  localparam int ID_W  = $clog2(NUM_P)
) (
  input  logic [NUM_P-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_id
);

  logic [ID_W-1:0] idx_s;

  // Scan from the farthest candidate down to ptr+1 so the nearest one wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ptr;
    idx_s   = ptr;
    for (int k = NUM_P; k >= 1; k--) begin
      idx_s   = ptr + ID_W'(k);
      gnt_vld = gnt_vld | req[idx_s];
      gnt_id  = req[idx_s] ? idx_s : gnt_id;
    end
  end

endmodule

// File: rtl/mrv1_tw_rr_sched.sv
// Round-robin warp scheduler with branch stall, thread-mask control and spawn.
// Barrier support is built only when MRV1_TW_BARRIER_EN is defined.
module mrv1_tw_rr_sched
  import mrv1_tw_pkg::*;
#(
  parameter  int          NUM_TW_P       = 8,
  parameter  int          WARP_SIZE_P    = 8,
  parameter  int          NUM_BARRIERS_P = 8,
  parameter  logic [31:0] RESET_PC_P     = 32'h0,
  localparam int          TW_ID_W        = $clog2(NUM_TW_P),
  localparam int          BAR_ID_W       = $clog2(NUM_BARRIERS_P)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_rdy_i,
  output logic                   sched_vld_o,
  output logic [TW_ID_W-1:0]     sched_twid_o,
  output logic [31:0]            sched_pc_o,
  output logic [WARP_SIZE_P-1:0] sched_tmask_o,
  input  logic                   fetch_rsp_vld_i,
  input  logic [TW_ID_W-1:0]     fetch_rsp_twid_i,
  input  logic                   br_vld_i,
  input  logic [TW_ID_W-1:0]     br_twid_i,
  input  logic                   br_taken_i,
  input  logic [31:0]            br_tgt_i,
  input  logic                   wstall_vld_i,
  input  logic [TW_ID_W-1:0]     wstall_twid_i,
  input  logic                   tmc_vld_i,
  input  logic [TW_ID_W-1:0]     tmc_twid_i,
  input  logic [WARP_SIZE_P-1:0] tmc_mask_i,
  input  logic                   wspawn_vld_i,
  input  logic [NUM_TW_P-1:0]    wspawn_mask_i,
  input  logic [31:0]            wspawn_pc_i,
  input  logic                   bar_vld_i,
  input  logic [TW_ID_W-1:0]     bar_twid_i,
  input  logic [BAR_ID_W-1:0]    bar_id_i,
  input  logic [TW_ID_W-1:0]     bar_cnt_m1_i
);

  tw_state_t           st_r     [NUM_TW_P];
  tw_state_t           st_nxt_s [NUM_TW_P];
  logic [TW_ID_W-1:0]  ptr_r;
  logic [NUM_TW_P-1:0] ready_s;
  logic [NUM_TW_P-1:0] bar_stalled_s;
  logic                gnt_vld_s;
  logic [TW_ID_W-1:0]  gnt_id_s;
  logic                fire_s;
  logic [NUM_TW_P-1:0] rsp_hit_s, fire_hit_s, br_hit_s, wstall_hit_s, tmc_hit_s, spawn_hit_s;
  logic                spawn_unused_s;

  // Warp 0 is never a spawn target, so its mask bit has no effect.
  assign spawn_unused_s = wspawn_mask_i[0];

  // Eligibility of each warp for selection.
  always_comb begin
    for (int i = 0; i < NUM_TW_P; i++) begin
      ready_s[i] = st_r[i].active & ~st_r[i].stalled & ~st_r[i].locked & ~bar_stalled_s[i];
    end
  end

  mrv1_rr_arbiter #(.NUM_P(NUM_TW_P)) u_arb (
    .req     (ready_s),
    .ptr     (ptr_r),
    .gnt_vld (gnt_vld_s),
    .gnt_id  (gnt_id_s)
  );

  assign fire_s        = gnt_vld_s & fetch_rdy_i;
  assign sched_vld_o   = gnt_vld_s;
  assign sched_twid_o  = gnt_id_s;
  assign sched_pc_o    = st_r[gnt_id_s].pc;
  assign sched_tmask_o = st_r[gnt_id_s].tmask[WARP_SIZE_P-1:0];

  // Per-warp decode of the event buses.
  always_comb begin
    spawn_hit_s = '0;
    for (int i = 0; i < NUM_TW_P; i++) begin
      rsp_hit_s[i]    = fetch_rsp_vld_i & (fetch_rsp_twid_i == TW_ID_W'(i));
      fire_hit_s[i]   = fire_s          & (gnt_id_s         == TW_ID_W'(i));
      br_hit_s[i]     = br_vld_i        & (br_twid_i        == TW_ID_W'(i));
      wstall_hit_s[i] = wstall_vld_i    & (wstall_twid_i    == TW_ID_W'(i));
      tmc_hit_s[i]    = tmc_vld_i       & (tmc_twid_i       == TW_ID_W'(i));
    end
    for (int i = 1; i < NUM_TW_P; i++) begin
      spawn_hit_s[i] = wspawn_vld_i & wspawn_mask_i[i];
    end
  end

  // Next warp state; a taken branch beats spawn and fetch PC updates, tmc beats spawn.
  always_comb begin
    for (int i = 0; i < NUM_TW_P; i++) begin
      st_nxt_s[i]         = st_r[i];
      st_nxt_s[i].locked  = (st_r[i].locked  & ~rsp_hit_s[i]) | fire_hit_s[i];
      st_nxt_s[i].stalled = (st_r[i].stalled & ~br_hit_s[i])  | wstall_hit_s[i];
      if (br_hit_s[i] & br_taken_i) begin
        st_nxt_s[i].pc = br_tgt_i;
      end else if (spawn_hit_s[i]) begin
        st_nxt_s[i].pc = wspawn_pc_i;
      end else if (fire_hit_s[i]) begin
        st_nxt_s[i].pc = st_r[i].pc + 32'd4;
      end else begin
        st_nxt_s[i].pc = st_r[i].pc;
      end
      if (tmc_hit_s[i]) begin
        st_nxt_s[i].tmask  = TMASK_MAX_W'(tmc_mask_i);
        st_nxt_s[i].active = |tmc_mask_i;
      end else if (spawn_hit_s[i]) begin
        st_nxt_s[i].tmask  = TMASK_MAX_W'(1'b1);
        st_nxt_s[i].active = 1'b1;
      end else begin
        st_nxt_s[i].tmask  = st_r[i].tmask;
        st_nxt_s[i].active = st_r[i].active;
      end
    end
  end

  // Warp state and round-robin pointer; reset drops every in-flight lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_TW_P; i++) begin
        st_r[i] <= tw_reset_state(i == 0, RESET_PC_P);
      end
      ptr_r <= TW_ID_W'(NUM_TW_P - 1);
    end else begin
      st_r  <= st_nxt_s;
      ptr_r <= fire_s ? gnt_id_s : ptr_r;
    end
  end

  // Mask bits above WARP_SIZE_P are always zero and never observed.
  if (WARP_SIZE_P < TMASK_MAX_W) begin : g_tmask_pad
    logic tmask_pad_unused_s;
    // Fold the padding bits so they are accounted for.
    always_comb begin
      tmask_pad_unused_s = 1'b0;
      for (int i = 0; i < NUM_TW_P; i++) begin
        tmask_pad_unused_s = tmask_pad_unused_s ^ (^st_r[i].tmask[TMASK_MAX_W-1:WARP_SIZE_P]);
      end
    end
  end

`ifdef MRV1_TW_BARRIER_EN
  logic [NUM_TW_P-1:0] bar_mask_r [NUM_BARRIERS_P];
  bar_cnt_t            bar_cnt_r  [NUM_BARRIERS_P];
  logic                bar_take_s;
  logic                bar_release_s;

  // A same-cycle tmc takes priority and the arrival is dropped.
  assign bar_take_s    = bar_vld_i & ~tmc_vld_i;
  assign bar_release_s = (bar_cnt_r[bar_id_i] == bar_cnt_t'(bar_cnt_m1_i));

  // A warp is held while any barrier has it parked.
  always_comb begin
    bar_stalled_s = '0;
    for (int b = 0; b < NUM_BARRIERS_P; b++) begin
      bar_stalled_s = bar_stalled_s | bar_mask_r[b];
    end
  end

  // Arrival counting; the last participant clears the barrier without stalling itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
        bar_mask_r[b] <= '0;
        bar_cnt_r[b]  <= '0;
      end
    end else if (bar_take_s) begin
      if (bar_release_s) begin
        bar_cnt_r[bar_id_i]  <= '0;
        bar_mask_r[bar_id_i] <= '0;
      end else begin
        bar_cnt_r[bar_id_i]              <= bar_cnt_r[bar_id_i] + bar_cnt_t'(1'b1);
        bar_mask_r[bar_id_i][bar_twid_i] <= 1'b1;
      end
    end
  end
`else
  logic bar_unused_s;

  assign bar_stalled_s = '0;
  assign bar_unused_s  = ^{bar_vld_i, bar_twid_i, bar_id_i, bar_cnt_m1_i};
`endif

endmodule
